// File: rtl/master_ocp_if.sv
// Bundle of user request/response and OCP master-side bus signals for master_ocp.
// The master modport is the view of the OCP master; slave is the view of its environment.
interface master_ocp_if #(
    parameter int DATAWIDTH    = 8,
    parameter int ADDRESSWIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [1:0]                req_len;
    logic [ADDRESSWIDTH-1:0]   req_addr;
    logic [4*DATAWIDTH-1:0]    req_wdata;
    logic                      done;
    logic                      rsp_err;
    logic [DATAWIDTH-1:0]      rsp_rdata;

    logic [2:0]                MCmd;
    logic [ADDRESSWIDTH-1:0]   MAddr;
    logic [DATAWIDTH-1:0]      MData;
    logic                      MDataValid;
    logic                      MDataLast;
    logic                      MRespAccept;
    logic [1:0]                id;
    logic                      SCmdAccept;
    logic [1:0]                SResp;
    logic [DATAWIDTH-1:0]      SData;
    logic                      SRespLast;

    modport master (
        input  req_valid, req_write, req_len, req_addr, req_wdata,
        input  SCmdAccept, SResp, SData, SRespLast,
        output req_ready, done, rsp_err, rsp_rdata,
        output MCmd, MAddr, MData, MDataValid, MDataLast, MRespAccept, id
    );

    modport slave (
        output req_valid, req_write, req_len, req_addr, req_wdata,
        output SCmdAccept, SResp, SData, SRespLast,
        input  req_ready, done, rsp_err, rsp_rdata,
        input  MCmd, MAddr, MData, MDataValid, MDataLast, MRespAccept, id
    );
endinterface

// File: rtl/master_ocp.sv
// Simple OCP master: takes one user request at a time, issues single or burst
// write / single read commands, collects the response, and reports done/err.
module master_ocp #(
    parameter int         DATAWIDTH    = 8,
    parameter int         ADDRESSWIDTH = 32,
    parameter logic [1:0] TARGET_ID    = 2'b01,
    parameter int         TIMEOUT      = 16
) (
    input  logic          clk,
    input  logic          rst,
    master_ocp_if.master  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Wait counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
    localparam int            TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]               state_q, state_d;
    logic                     write_q, write_d;
    logic [1:0]               len_q, len_d;
    logic [ADDRESSWIDTH-1:0]  addr_q, addr_d;
    logic [4*DATAWIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]               beat_q, beat_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     err_q, err_d;
    logic [DATAWIDTH-1:0]     rdata_q, rdata_d;
    logic                     racc_q, racc_d;

    logic [DATAWIDTH-1:0]     beat_data [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_beat
        assign beat_data[gi] = wdata_q[gi*DATAWIDTH +: DATAWIDTH];
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        racc_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    len_d   = bus.req_write ? bus.req_len : 2'b00;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    beat_d  = 2'd0;
                    tmo_d   = '0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (bus.SCmdAccept) begin
                    tmo_d = '0;
                    if (beat_q < len_q) begin
                        beat_d = beat_q + 2'd1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.SResp != 2'b00) begin
                    // 01 is DVA; both 10 and 11 count as failure.
                    err_d = bus.SResp[1];
                    if (!write_q) begin
                        rdata_d = bus.SData;
                    end
                    racc_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            len_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            beat_q  <= 2'd0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            racc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            racc_q  <= racc_d;
        end
    end

    logic in_cmd;
    logic [2:0] cmd_code;

    assign in_cmd   = (state_q == ST_CMD);
    assign cmd_code = !write_q        ? 3'b010 :
                      (len_q == 2'b00) ? 3'b001 : {1'b1, len_q};

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.rsp_err     = err_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.MCmd        = in_cmd ? cmd_code : 3'b000;
    assign bus.MAddr       = in_cmd ? (addr_q + ADDRESSWIDTH'(beat_q)) : '0;
    assign bus.MData       = (in_cmd && write_q) ? beat_data[beat_q] : '0;
    assign bus.MDataValid  = in_cmd && write_q;
    assign bus.MDataLast   = in_cmd && write_q && (beat_q == len_q);
    // Accept is combinational on the response cycle, then held one more cycle in DONE.
    assign bus.MRespAccept = ((state_q == ST_RESP) && (bus.SResp != 2'b00)) || racc_q;
    assign bus.id          = (in_cmd || (state_q == ST_RESP)) ? TARGET_ID : 2'b00;
endmodule

// File: tb/tb_master_ocp.sv
// Directed bench for master_ocp: a transaction-level model predicts every output
// each cycle; observed counters are also pinned against hand-computed literals.
module tb_master_ocp;
    localparam int         DW  = 8;
    localparam int         AW  = 32;
    localparam int         TMO = 16;
    localparam logic [1:0] TID = 2'b01;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    master_ocp_if #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW)) bus ();

    master_ocp #(
        .DATAWIDTH(DW), .ADDRESSWIDTH(AW), .TARGET_ID(TID), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs for the current cycle
    logic        e_valid = 1'b0;
    logic        e_ready, e_done, e_err, e_mdv, e_mdl, e_mra;
    logic        e_chk_addr, e_chk_mdata;
    logic [7:0]  e_rdata, e_mdata;
    logic [2:0]  e_mcmd;
    logic [31:0] e_maddr;
    logic [1:0]  e_id;

    // Model state: result of the last completed transaction
    logic        m_err;
    logic [7:0]  m_rdata;

    // Observations made by the compare process
    int          obs_cmd = 0, obs_mra = 0, obs_done = 0;
    logic [7:0]  obs_rdata = '0;
    logic        obs_err = 1'b0;
    logic [31:0] obs_last_addr = '0, obs_dshift = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_len    = 2'b00;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.SCmdAccept = 1'b0;
        bus.SResp      = 2'b00;
        bus.SData      = '0;
        bus.SRespLast  = 1'b0;
    endtask

    // Noise on every input the master must ignore while busy
    task automatic busy_inputs();
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_write  = 1'($urandom);
        bus.req_len    = 2'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        bus.SCmdAccept = 1'b0;
        bus.SResp      = 2'b00;
        bus.SData      = 8'($urandom);
        bus.SRespLast  = 1'($urandom);
    endtask

    task automatic exp_quiet(input logic ready, input logic done, input logic [1:0] idv);
        e_ready = ready; e_done = done; e_mcmd = 3'b000; e_mdv = 1'b0; e_mdl = 1'b0;
        e_mra = 1'b0; e_id = idv; e_chk_addr = 1'b0; e_chk_mdata = 1'b0;
        e_maddr = '0; e_mdata = '0; e_err = m_err; e_rdata = m_rdata;
    endtask

    task automatic idle_cycle();
        next_cycle();
        quiet_inputs();
        exp_quiet(1'b1, 1'b0, 2'b00);
    endtask

    task automatic exp_cmd(input logic wr, input logic [2:0] enc, input logic [31:0] addr,
                           input logic [31:0] wdata, input int b, input int last);
        exp_quiet(1'b0, 1'b0, TID);
        e_mcmd = enc;
        e_maddr = addr + 32'(b);
        e_chk_addr = 1'b1;
        e_mdv = wr;
        e_mdl = wr && (b == last);
        e_mdata = 8'(wdata >> (8 * b));
        e_chk_mdata = wr;
    endtask

    // One full request: acc0/accn = stall cycles before accepting first/other beats,
    // rwait = cycles of SResp=00 before the response.
    task automatic run_txn(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] wdata, input int acc0, input int accn,
                           input int rwait, input logic [1:0] resp, input logic [7:0] sdata);
        int last;
        logic [2:0] enc;
        bit tmo;
        bit responded;
        int waited;
        last = wr ? int'(len) : 0;
        enc = !wr ? 3'b010 : (len == 2'b00 ? 3'b001 : {1'b1, len});
        tmo = 0;
        responded = 0;

        next_cycle();
        quiet_inputs();
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_len = len;
        bus.req_addr = addr; bus.req_wdata = wdata;
        exp_quiet(1'b1, 1'b0, 2'b00);

        for (int b = 0; b <= last && !tmo; b++) begin
            waited = 0;
            while (1) begin
                next_cycle();
                busy_inputs();
                exp_cmd(wr, enc, addr, wdata, b, last);
                bus.SCmdAccept = (waited == ((b == 0) ? acc0 : accn));
                if (bus.SCmdAccept) break;
                waited++;
                if (waited == TMO) begin
                    tmo = 1;
                    break;
                end
            end
        end

        if (!tmo) begin
            waited = 0;
            while (1) begin
                next_cycle();
                busy_inputs();
                exp_quiet(1'b0, 1'b0, TID);
                if (waited == rwait) begin
                    bus.SResp = resp;
                    bus.SData = sdata;
                    bus.SRespLast = 1'b1;
                    e_mra = 1'b1;
                    responded = 1;
                    break;
                end
                waited++;
                if (waited == TMO) begin
                    tmo = 1;
                    break;
                end
            end
        end

        if (tmo) begin
            m_err = 1'b1;
        end else begin
            m_err = resp[1];
            if (!wr) m_rdata = sdata;
        end

        next_cycle();
        busy_inputs();
        exp_quiet(1'b0, 1'b1, 2'b00);
        e_mra = responded;
    endtask

    initial begin
        int b_cmd, b_mra, b_done;
        rst = 1'b1;
        m_err = 1'b0;
        m_rdata = '0;
        quiet_inputs();
        exp_quiet(1'b1, 1'b0, 2'b00);

        fork
            forever begin
                @(negedge clk);
                if (e_valid) begin
                    chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
                    chk("done", 32'(bus.done), 32'(e_done));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
                    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e_rdata));
                    chk("MCmd", 32'(bus.MCmd), 32'(e_mcmd));
                    chk("MDataValid", 32'(bus.MDataValid), 32'(e_mdv));
                    chk("MDataLast", 32'(bus.MDataLast), 32'(e_mdl));
                    chk("MRespAccept", 32'(bus.MRespAccept), 32'(e_mra));
                    chk("id", 32'(bus.id), 32'(e_id));
                    if (e_chk_addr) chk("MAddr", bus.MAddr, e_maddr);
                    if (e_chk_mdata) chk("MData", 32'(bus.MData), 32'(e_mdata));
                    if (bus.MCmd != 3'b000) obs_cmd++;
                    if (bus.MRespAccept) obs_mra++;
                    if (bus.MDataLast) obs_last_addr = bus.MAddr;
                    if (bus.MDataValid) obs_dshift = {obs_dshift[23:0], bus.MData};
                    if (bus.done) begin
                        obs_done++;
                        obs_rdata = bus.rsp_rdata;
                        obs_err = bus.rsp_err;
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        next_cycle();
        rst = 1'b0;
        quiet_inputs();
        exp_quiet(1'b1, 1'b0, 2'b00);
        e_valid = 1'b1;
        idle_cycle();

        // Single write, accepted after 2 stall cycles
        b_cmd = obs_cmd; b_done = obs_done;
        run_txn(1'b1, 2'd0, 32'h10, 32'h0000_00A5, 2, 0, 1, 2'b01, 8'h00);
        idle_cycle();
        chk("pin_single_cmd_cycles", 32'(obs_cmd - b_cmd), 32'd3);
        chk("pin_single_done", 32'(obs_done - b_done), 32'd1);
        chk("pin_single_err", 32'(obs_err), 32'd0);

        // Four-beat burst, accepted every cycle
        b_cmd = obs_cmd;
        run_txn(1'b1, 2'd3, 32'h10, 32'h4433_2211, 0, 0, 0, 2'b01, 8'h00);
        idle_cycle();
        chk("pin_burst_cmd_cycles", 32'(obs_cmd - b_cmd), 32'd4);
        chk("pin_burst_last_addr", obs_last_addr, 32'h13);
        chk("pin_burst_data_order", obs_dshift, 32'h1122_3344);

        // Read, response after 3 cycles
        b_mra = obs_mra;
        run_txn(1'b0, 2'd3, 32'h20, 32'hDEAD_BEEF, 0, 0, 3, 2'b01, 8'h5C);
        idle_cycle();
        chk("pin_read_rdata", 32'(obs_rdata), 32'h5C);
        chk("pin_read_mra_cycles", 32'(obs_mra - b_mra), 32'd2);

        // Error response, then a normal request right after
        run_txn(1'b1, 2'd0, 32'h30, 32'h0000_0077, 0, 0, 2, 2'b11, 8'h00);
        idle_cycle();
        chk("pin_error_err", 32'(obs_err), 32'd1);
        run_txn(1'b1, 2'd2, 32'h40, 32'h00CC_BBAA, 1, 2, 0, 2'b01, 8'h00);
        idle_cycle();
        chk("pin_after_error_err", 32'(obs_err), 32'd0);

        // Burst crossing the top of the address space; SResp=10 also errors
        run_txn(1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_9988, 0, 0, 0, 2'b10, 8'h00);
        idle_cycle();

        // Command-phase timeout
        b_cmd = obs_cmd; b_mra = obs_mra;
        run_txn(1'b1, 2'd0, 32'h50, 32'h0000_0001, 100, 0, 0, 2'b01, 8'h00);
        idle_cycle();
        chk("pin_tmo_cmd_cycles", 32'(obs_cmd - b_cmd), 32'd16);
        chk("pin_tmo_mra", 32'(obs_mra - b_mra), 32'd0);
        chk("pin_tmo_err", 32'(obs_err), 32'd1);

        // Response-phase timeout on a read keeps the old read data
        b_mra = obs_mra;
        run_txn(1'b0, 2'd0, 32'h60, 32'h0, 0, 0, 100, 2'b01, 8'h99);
        idle_cycle();
        chk("pin_resp_tmo_mra", 32'(obs_mra - b_mra), 32'd0);
        chk("pin_resp_tmo_rdata", 32'(obs_rdata), 32'h5C);

        // Reset in the middle of a burst, after the first beat is accepted
        b_done = obs_done;
        next_cycle();
        quiet_inputs();
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_len = 2'd3;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h4433_2211;
        exp_quiet(1'b1, 1'b0, 2'b00);
        next_cycle();
        quiet_inputs();
        bus.SCmdAccept = 1'b1;
        exp_cmd(1'b1, 3'b111, 32'h10, 32'h4433_2211, 0, 3);
        next_cycle();
        quiet_inputs();
        rst = 1'b1;
        exp_cmd(1'b1, 3'b111, 32'h10, 32'h4433_2211, 1, 3);
        next_cycle();
        rst = 1'b0;
        quiet_inputs();
        m_err = 1'b0;
        m_rdata = '0;
        exp_quiet(1'b1, 1'b0, 2'b00);
        repeat (4) idle_cycle();
        chk("pin_reset_no_done", 32'(obs_done - b_done), 32'd0);

        // Normal operation resumes after reset
        run_txn(1'b0, 2'd0, 32'h70, 32'h0, 1, 0, 0, 2'b01, 8'h3E);
        idle_cycle();
        chk("pin_post_reset_rdata", 32'(obs_rdata), 32'h3E);

        next_cycle();
        e_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/master_ocp.md
MASTER_OCP -- requirements
Module: master_ocp

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning data bus width in bits.
REQ-002 SHALL have parameter ADDRESSWIDTH, default 32, meaning address bus width in bits.
REQ-003 SHALL have parameter TARGET_ID, default 2'b01, meaning slave select value driven on id.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning maximum wait cycles per phase before abort.
REQ-005 SHALL have port clk, input, 1, the clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port req_valid, input, 1, user request present.
REQ-008 SHALL have port req_ready, output, 1, master can accept a request.
REQ-009 SHALL have port req_write, input, 1, 1=write, 0=read.
REQ-010 SHALL have port req_len, input, 2, beats minus one (write only).
REQ-011 SHALL have port req_addr, input, ADDRESSWIDTH, start address.
REQ-012 SHALL have port req_wdata, input, 4*DATAWIDTH, packed write beats; beat i = bits [i*DATAWIDTH +: DATAWIDTH].
REQ-013 SHALL have port done, output, 1, one-cycle transaction-complete pulse.
REQ-014 SHALL have port rsp_err, output, 1, error status of last transaction, valid with done.
REQ-015 SHALL have port rsp_rdata, output, DATAWIDTH, read data, valid with done.
REQ-016 SHALL have ports MCmd (output, 3), MAddr (output, ADDRESSWIDTH), MData (output, DATAWIDTH), MDataValid (output, 1), MDataLast (output, 1), MRespAccept (output, 1), id (output, 2).
REQ-017 SHALL have ports SCmdAccept (input, 1), SResp (input, 2), SData (input, DATAWIDTH), SRespLast (input, 1).

Function
REQ-018 SHALL implement states IDLE, CMD, RESP, DONE; req_ready = 1 only in IDLE.
REQ-019 SHALL, in IDLE with req_valid=1, capture req_* into internal registers, clear beat counter and timeout counter, and enter CMD next cycle.
REQ-020 SHALL encode MCmd as: 000 idle; 010 read; 001 write when len=0; {1'b1, len} burst write when len>0 (100/101/110/111 reserved: 100 unused, 101=2, 110=3, 111=4 beats).
REQ-021 SHALL force len to 0 for reads, so reads are always single-beat.
REQ-022 SHALL, in CMD, drive MCmd, MAddr = start address + beat, MData = beat slice, MDataValid = req_write, id = TARGET_ID, and hold them unchanged until SCmdAccept=1 is sampled.
REQ-023 SHALL assert MDataLast in CMD when beat == len for writes.
REQ-024 SHALL, on SCmdAccept=1 in CMD, advance beat by 1 and reset the timeout counter if beat < len; otherwise go to RESP.
REQ-025 SHALL drive MCmd=000, MDataValid=0, MDataLast=0 in every state other than CMD.
REQ-026 SHALL, in RESP, wait for SResp != 00; SResp=01 (DVA) means success, 10 or 11 means error.
REQ-027 SHALL, on the first sampled non-zero SResp in RESP, register rsp_err, register rsp_rdata = SData for reads (rsp_rdata unchanged for writes), assert MRespAccept for exactly that cycle plus the next cycle, and go to DONE.
REQ-028 SHALL ignore SRespLast for control and SHALL treat it only as an informational input.
REQ-029 SHALL pulse done = 1 for exactly one cycle in DONE, then return to IDLE.
REQ-030 SHALL count cycles spent in CMD without SCmdAccept, or in RESP without a response; on reaching TIMEOUT it SHALL set rsp_err = 1 and go to DONE without asserting MRespAccept.
REQ-031 SHALL keep id = TARGET_ID in CMD and RESP, and 2'b00 in IDLE and DONE.
REQ-032 SHALL wrap MAddr increments modulo 2^ADDRESSWIDTH.
REQ-033 SHALL ignore req_valid outside IDLE, with no queueing.

Reset
REQ-034 SHALL, while rst=1 at a clock edge, enter IDLE and clear all outputs to 0 (req_ready becomes 1 as IDLE is entered), clear all counters, and clear rsp_err and rsp_rdata.
REQ-035 SHALL, on reset mid-transaction, abandon it with no done pulse, and drive MCmd=000 from the cycle after the reset edge.

Verification
REQ-036 Single write: addr 0x10, data 0xA5, len 0, SCmdAccept after 2 cycles, SResp=01 -> MCmd=001 held 3 cycles, MDataLast=1, done=1, rsp_err=0.
REQ-037 Burst write: len 3, data 0x44332211, SCmdAccept every cycle -> MCmd=111, MAddr 0x10..0x13, MData 11,22,33,44, MDataLast only on 0x13.
REQ-038 Read: addr 0x20, SCmdAccept=1, SResp=01 with SData=0x5C after 3 cycles -> MCmd=010, rsp_rdata=0x5C, MRespAccept high 2 cycles, done pulse.
REQ-039 Error: write with SResp=11 -> done=1, rsp_err=1; next request is accepted normally.
REQ-040 Timeout: SCmdAccept held 0 -> after 16 cycles done=1, rsp_err=1, MCmd=000, MRespAccept never high.
REQ-041 Reset mid-burst after beat 1 accepted -> next cycle IDLE, MCmd=000, req_ready=1, no done pulse.
